timer_tick_scheduler: RTL and testbench
=======================================

# timer_tick_scheduler

Sequencer and sharer for the system interval timer. Enables the timer's interrupt, services each timeout over the timer's 16-bit register port by clearing its status, and fans each base tick out to NUM_CH independently programmable software-style channels. Each channel has its own period, expiry pulse and sticky pending flag. Sits between the interval timer slave and the vision/control logic that needs periodic events.

## Interface
Parameters:
- NUM_CH, 4, number of scheduled channels (1..16)
- CNT_W, 16, width of channel period/count in base ticks

Ports:
- clk  in  1  system clock; single clock domain
- reset_n  in  1  reset, synchronous, active-low
- tmr_irq  in  1  interrupt from interval timer (level, high until status cleared)
- tmr_address  out  3  timer register address
- tmr_chipselect  out  1  timer select
- tmr_write_n  out  1  timer write strobe, active-low
- tmr_writedata  out  16  timer write data
- ch_wr  in  1  configuration write strobe
- ch_sel  in  4  channel index for ch_wr (values >= NUM_CH ignored)
- ch_period  in  CNT_W  period in ticks; 0 = channel never expires
- ch_en  in  1  channel enable loaded with ch_wr
- pend_ack  in  NUM_CH  per-channel pending clear, one bit per channel
- ch_expire  out  NUM_CH  one-cycle expiry pulses
- ch_pending  out  NUM_CH  sticky pending flags
- sched_irq  out  1  OR of ch_pending
- tick_count  out  32  free-running count of serviced base ticks, wraps
- init_done  out  1  high once the timer control write has been issued

## Operation
- FSM states: INIT_CTRL, IDLE, CLEAR, TICK.
- INIT_CTRL (entered from reset):
  - drives a write: chipselect=1, write_n=0, address=1, writedata=16'h0001 (interrupt enable);
  - next state IDLE; init_done set and held.
- IDLE: no bus activity; tmr_irq sampled high -> CLEAR.
- CLEAR:
  - drives a write: address=0, writedata=0 (clears timeout);
  - next state TICK.
- TICK:
  - one cycle, no bus activity;
  - tick_count += 1 (wraps at 2^32);
  - all channels are updated at the end of this cycle;
  - next state IDLE.
- Bus outputs outside write states: chipselect=0, write_n=1, address=0, writedata=0. The timer has no waitrequest; each write completes in its single cycle.
- Channel update on tick, for a channel with en=1 and period!=0:
  - if count<=1: ch_expire=1, pending<=1, count<=period;
  - else count<=count-1.
  - Net effect: period P expires every P ticks; P=1 expires every tick.
- Channels with en=0 or period=0 hold their count and never expire.
- ch_wr to channel k loads period, count<=period, en<=ch_en, and clears pending[k].
- Same-cycle ch_wr and tick update on channel k: the write wins, no expiry that tick. Other channels update normally.
- Same-cycle pend_ack[k] and expiry on k: pending[k] stays 1 (set wins). pend_ack on a non-pending channel has no effect.
- Counts are unsigned CNT_W bits; the reload path never underflows.

## Timing
- All outputs are registered.
- Reset values:
  - FSM=INIT_CTRL;
  - tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0;
  - init_done=0, tick_count=0;
  - ch_expire=0, ch_pending=0, sched_irq=0;
  - all period, count and en = 0.
- Init write occurs in the first cycle after reset_n is sampled high.
- Tick latency:
  - tmr_irq sampled high in IDLE at cycle n;
  - cycle n+1: CLEAR write on bus;
  - cycle n+2: TICK;
  - cycle n+3: ch_expire pulse, ch_pending and sched_irq high, tick_count updated.
- tmr_irq is low from cycle n+2, because the timer clears on the write edge. IDLE is therefore never re-entered with a stale irq.
- Minimum tick service period is 3 cycles. The base timer period is far longer, so no tick is lost.
- Reset mid-operation (any state, including a pending write): next cycle returns to reset values and restarts at INIT_CTRL, re-enabling the timer interrupt. Channel configuration is lost.

## Structure
- Shared package timer_sched_pkg holds:
  - state enum;
  - TMR_ADDR_STATUS=3'd0, TMR_ADDR_CONTROL=3'd1;
  - CTRL_ITO=16'h0001.
- Sub-module timer_sched_channel: one channel's period, count, en, pending and expire logic, instantiated NUM_CH times by generate. Inputs: tick, wr, period, en, ack.
- The top level holds the FSM, the bus drivers and tick_count.

## Test plan
- Reset release: cycle 1 shows write to address 1 with data 0x0001, init_done=1 thereafter; no further bus writes while tmr_irq=0.
- Channel 0 period 3 enabled, pulse tmr_irq 9 times (held until CLEAR): ch_expire[0] on ticks 3, 6, 9; each expire 3 cycles after irq; status write of address 0, data 0 each time; tick_count=9.
- Channels 1 and 2: ch 1 period 0 enabled, ch 2 period 2 disabled; 4 ticks -> neither expires; ch_pending=0, sched_irq=0.
- ch 3 period 1: ch_pending[3] and sched_irq set on first tick; pend_ack[3] asserted in the same cycle as the next expiry -> pending stays 1; ack on the following cycle -> pending 0, sched_irq 0.
- ch_wr to ch 0 (period 5) in the TICK cycle where count=1 -> no expire; next expiry 5 ticks later.
- Assert reset_n=0 during CLEAR -> bus idle next cycle, all channels cleared, init write repeated after release.

Source files
------------

// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg
//   Shared definitions for the interval timer tick scheduler: the FSM state
//   encoding, the timer register map and the control word written at init.
package timer_sched_pkg;

   typedef enum logic [1:0] {
      StInitCtrl,
      StIdle,
      StClear,
      StTick
   } state_e;

   localparam logic [2:0]  TMR_ADDR_STATUS  = 3'd0;
   localparam logic [2:0]  TMR_ADDR_CONTROL = 3'd1;
   localparam logic [15:0] CTRL_ITO         = 16'h0001;

endpackage

// File: rtl/timer_sched_channel.sv
// timer_sched_channel
//   One scheduled channel: holds period, down-count, enable and a sticky
//   pending flag, and emits a one-cycle expiry pulse on the base tick that
//   exhausts its count.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset
//   tick           base tick (one cycle, from the top FSM TICK state)
//   wr             configuration write for this channel
//   period, en     configuration loaded by wr
//   ack            pending clear
//   expire         registered one-cycle expiry pulse
//   pending        registered sticky pending flag
//   pending_next   next-state of pending, used to register the shared irq
module timer_sched_channel #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             tick,
   input  logic             wr,
   input  logic [CNT_W-1:0] period,
   input  logic             en,
   input  logic             ack,
   output logic             expire,
   output logic             pending,
   output logic             pending_next
);

   logic [CNT_W-1:0] period_q, count_q, count_d;
   logic             en_q;
   logic             active;
   logic             fire;

   always_comb begin
      active = tick && en_q && (period_q != '0);
      // A configuration write in the same cycle overrides the tick.
      fire   = active && (count_q <= CNT_W'(1)) && !wr;

      count_d = count_q;
      if (wr) begin
         count_d = period;
      end else if (active) begin
         count_d = (count_q <= CNT_W'(1)) ? period_q : count_q - CNT_W'(1);
      end

      // Set wins over ack; a write always clears.
      pending_next = pending;
      if (wr) begin
         pending_next = 1'b0;
      end else if (fire) begin
         pending_next = 1'b1;
      end else if (ack) begin
         pending_next = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         period_q <= '0;
         count_q  <= '0;
         en_q     <= 1'b0;
         expire   <= 1'b0;
         pending  <= 1'b0;
      end else begin
         if (wr) begin
            period_q <= period;
            en_q     <= en;
         end
         count_q <= count_d;
         expire  <= fire;
         pending <= pending_next;
      end
   end

endmodule

// File: rtl/timer_tick_scheduler.sv
// timer_tick_scheduler
//   Enables the interval timer interrupt, clears each timeout over the
//   timer register port, counts serviced base ticks and fans each tick out
//   to NUM_CH programmable channels.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   tmr_irq               timer interrupt (level)
//   tmr_address/chipselect/write_n/writedata   timer register write port
//   ch_wr, ch_sel, ch_period, ch_en            channel configuration write
//   pend_ack              per-channel pending clear
//   ch_expire, ch_pending per-channel expiry pulses and sticky flags
//   sched_irq             OR of ch_pending
//   tick_count            serviced base ticks, wrapping
//   init_done             high once the control write has been issued
module timer_tick_scheduler
   import timer_sched_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              tmr_irq,
   output logic [2:0]        tmr_address,
   output logic              tmr_chipselect,
   output logic              tmr_write_n,
   output logic [15:0]       tmr_writedata,
   input  logic              ch_wr,
   input  logic [3:0]        ch_sel,
   input  logic [CNT_W-1:0]  ch_period,
   input  logic              ch_en,
   input  logic [NUM_CH-1:0] pend_ack,
   output logic [NUM_CH-1:0] ch_expire,
   output logic [NUM_CH-1:0] ch_pending,
   output logic              sched_irq,
   output logic [31:0]       tick_count,
   output logic              init_done
);

   state_e state_q, state_d;

   logic        cs_d, wn_d;
   logic [2:0]  addr_d;
   logic [15:0] data_d;

   logic [NUM_CH-1:0] ch_wr_k;
   logic [NUM_CH-1:0] pend_next;

   // State register and registered outputs
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= StInitCtrl;
         tmr_chipselect <= 1'b0;
         tmr_write_n    <= 1'b1;
         tmr_address    <= 3'd0;
         tmr_writedata  <= 16'h0000;
         init_done      <= 1'b0;
         tick_count     <= 32'd0;
         sched_irq      <= 1'b0;
      end else begin
         state_q        <= state_d;
         tmr_chipselect <= cs_d;
         tmr_write_n    <= wn_d;
         tmr_address    <= addr_d;
         tmr_writedata  <= data_d;
         if (state_q == StInitCtrl) begin
            init_done <= 1'b1;
         end
         if (state_q == StTick) begin
            tick_count <= tick_count + 32'd1;
         end
         sched_irq <= |pend_next;
      end
   end

   // Next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StInitCtrl: state_d = StIdle;
         StIdle:     if (tmr_irq) state_d = StClear;
         StClear:    state_d = StTick;
         StTick:     state_d = StIdle;
         default:    state_d = StInitCtrl;
      endcase
   end

   // Bus outputs are registered, so the write is decoded one cycle ahead:
   // the init write goes out in the cycle after reset release and the
   // status clear is on the bus while the FSM sits in CLEAR.
   always_comb begin
      cs_d   = 1'b0;
      wn_d   = 1'b1;
      addr_d = TMR_ADDR_STATUS;
      data_d = 16'h0000;
      unique case (state_q)
         StInitCtrl: begin
            cs_d   = 1'b1;
            wn_d   = 1'b0;
            addr_d = TMR_ADDR_CONTROL;
            data_d = CTRL_ITO;
         end
         StIdle: begin
            if (state_d == StClear) begin
               cs_d   = 1'b1;
               wn_d   = 1'b0;
               addr_d = TMR_ADDR_STATUS;
               data_d = 16'h0000;
            end
         end
         default: ;
      endcase
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign ch_wr_k[k] = ch_wr && (ch_sel == 4'(k));

      timer_sched_channel #(
         .CNT_W (CNT_W)
      ) u_ch (
         .clk          (clk),
         .reset_n      (reset_n),
         .tick         (state_q == StTick),
         .wr           (ch_wr_k[k]),
         .period       (ch_period),
         .en           (ch_en),
         .ack          (pend_ack[k]),
         .expire       (ch_expire[k]),
         .pending      (ch_pending[k]),
         .pending_next (pend_next[k])
      );
   end

endmodule

// File: tb/tb_timer_tick_scheduler.sv
module tb_timer_tick_scheduler;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned CNT_W  = 16;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              tmr_irq = 1'b0;
   logic [2:0]        tmr_address;
   logic              tmr_chipselect;
   logic              tmr_write_n;
   logic [15:0]       tmr_writedata;
   logic              ch_wr = 1'b0;
   logic [3:0]        ch_sel = 4'd0;
   logic [CNT_W-1:0]  ch_period = '0;
   logic              ch_en = 1'b0;
   logic [NUM_CH-1:0] pend_ack = '0;
   logic [NUM_CH-1:0] ch_expire;
   logic [NUM_CH-1:0] ch_pending;
   logic              sched_irq;
   logic [31:0]       tick_count;
   logic              init_done;

   int checks = 0;
   int errors = 0;

   timer_tick_scheduler #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .tmr_irq        (tmr_irq),
      .tmr_address    (tmr_address),
      .tmr_chipselect (tmr_chipselect),
      .tmr_write_n    (tmr_write_n),
      .tmr_writedata  (tmr_writedata),
      .ch_wr          (ch_wr),
      .ch_sel         (ch_sel),
      .ch_period      (ch_period),
      .ch_en          (ch_en),
      .pend_ack       (pend_ack),
      .ch_expire      (ch_expire),
      .ch_pending     (ch_pending),
      .sched_irq      (sched_irq),
      .tick_count     (tick_count),
      .init_done      (init_done)
   );

   always #5 clk = ~clk;

   // Tasks start and end at a falling edge.
   task automatic write_ch(input logic [3:0] sel, input logic [CNT_W-1:0] per, input logic en);
      ch_wr = 1'b1; ch_sel = sel; ch_period = per; ch_en = en;
      @(negedge clk);
      ch_wr = 1'b0;
   endtask

   // One timer timeout: irq raised in IDLE, dropped after the clear write
   // edge. Optional channel write / ack are driven during the TICK cycle.
   task automatic run_tick(
      input  logic              wr,
      input  logic [3:0]        sel,
      input  logic [CNT_W-1:0]  per,
      input  logic              en,
      input  logic [NUM_CH-1:0] ack,
      output logic              c_cs,
      output logic              c_wn,
      output logic [2:0]        c_addr,
      output logic [15:0]       c_data,
      output logic [NUM_CH-1:0] exp_mid,
      output logic [NUM_CH-1:0] exp_o,
      output logic [NUM_CH-1:0] pend_o,
      output logic              irq_o,
      output logic [31:0]       cnt_o
   );
      tmr_irq = 1'b1;
      @(negedge clk);
      c_cs = tmr_chipselect; c_wn = tmr_write_n; c_addr = tmr_address; c_data = tmr_writedata;
      @(posedge clk);
      #1 tmr_irq = 1'b0;
      @(negedge clk);
      exp_mid = ch_expire;
      ch_wr = wr; ch_sel = sel; ch_period = per; ch_en = en; pend_ack = ack;
      @(negedge clk);
      exp_o = ch_expire; pend_o = ch_pending; irq_o = sched_irq; cnt_o = tick_count;
      ch_wr = 1'b0; pend_ack = '0;
   endtask

   logic              c_cs, c_wn, irq_o;
   logic [2:0]        c_addr;
   logic [15:0]       c_data;
   logic [NUM_CH-1:0] exp_mid, exp_o, pend_o;
   logic [31:0]       cnt_o;

   task automatic test_reset();
      logic bad;
      reset_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (tmr_chipselect !== 1'b0 || tmr_write_n !== 1'b1 || tmr_address !== 3'd0 ||
          tmr_writedata !== 16'h0) begin
         errors++;
         $display("FAIL reset_bus: cs=%b wn=%b addr=%0d data=%h, required cs=0 wn=1 addr=0 data=0000",
                  tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
      end
      checks++;
      if (init_done !== 1'b0 || tick_count !== 32'd0 || ch_expire !== 4'b0 ||
          ch_pending !== 4'b0 || sched_irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: init=%b cnt=%0d exp=%b pend=%b irq=%b, required all 0",
                  init_done, tick_count, ch_expire, ch_pending, sched_irq);
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (tmr_chipselect !== 1'b1 || tmr_write_n !== 1'b0 || tmr_address !== 3'd1 ||
          tmr_writedata !== 16'h0001) begin
         errors++;
         $display("FAIL init_write: cs=%b wn=%b addr=%0d data=%h, required cs=1 wn=0 addr=1 data=0001",
                  tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
      end
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (tmr_chipselect !== 1'b0 || tmr_write_n !== 1'b1 || init_done !== 1'b1) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin
         errors++;
         $display("FAIL idle_quiet: bus activity or init_done low seen=%b, required 0", bad);
      end
   endtask

   task automatic test_periodic();
      logic [NUM_CH-1:0] want;
      write_ch(4'd0, 16'd3, 1'b1);
      for (int t = 1; t <= 9; t++) begin
         run_tick(1'b0, 4'd0, '0, 1'b0, '0, c_cs, c_wn, c_addr, c_data, exp_mid, exp_o, pend_o,
                  irq_o, cnt_o);
         want = (t % 3 == 0) ? 4'b0001 : 4'b0000;
         checks++;
         if (c_cs !== 1'b1 || c_wn !== 1'b0 || c_addr !== 3'd0 || c_data !== 16'h0) begin
            errors++;
            $display("FAIL clear_write t=%0d: cs=%b wn=%b addr=%0d data=%h, required 1 0 0 0000",
                     t, c_cs, c_wn, c_addr, c_data);
         end
         checks++;
         if (exp_mid !== 4'b0 || exp_o !== want) begin
            errors++;
            $display("FAIL periodic_expire t=%0d: mid=%b post=%b, required mid=0000 post=%b",
                     t, exp_mid, exp_o, want);
         end
      end
      checks++;
      if (cnt_o !== 32'd9) begin
         errors++;
         $display("FAIL tick_count: got %0d, required 9", cnt_o);
      end
      @(negedge clk);
      checks++;
      if (ch_expire !== 4'b0) begin
         errors++;
         $display("FAIL expire_pulse_width: got %b, required 0000", ch_expire);
      end
      write_ch(4'd0, 16'd0, 1'b0);
   endtask

   task automatic test_disabled();
      logic bad;
      write_ch(4'd1, 16'd0, 1'b1);
      write_ch(4'd2, 16'd2, 1'b0);
      bad = 1'b0;
      for (int t = 0; t < 4; t++) begin
         run_tick(1'b0, 4'd0, '0, 1'b0, 4'b0010, c_cs, c_wn, c_addr, c_data, exp_mid, exp_o,
                  pend_o, irq_o, cnt_o);
         if (exp_o !== 4'b0 || pend_o !== 4'b0 || irq_o !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0 || ch_pending !== 4'b0 || sched_irq !== 1'b0) begin
         errors++;
         $display("FAIL disabled_channels: exp=%b pend=%b irq=%b, required 0000 0000 0",
                  exp_o, ch_pending, sched_irq);
      end
   endtask

   task automatic test_ack();
      write_ch(4'd3, 16'd1, 1'b1);
      run_tick(1'b0, 4'd0, '0, 1'b0, '0, c_cs, c_wn, c_addr, c_data, exp_mid, exp_o, pend_o,
               irq_o, cnt_o);
      checks++;
      if (exp_o !== 4'b1000 || pend_o !== 4'b1000 || irq_o !== 1'b1) begin
         errors++;
         $display("FAIL p1_first_tick: exp=%b pend=%b irq=%b, required 1000 1000 1",
                  exp_o, pend_o, irq_o);
      end
      run_tick(1'b0, 4'd0, '0, 1'b0, 4'b1000, c_cs, c_wn, c_addr, c_data, exp_mid, exp_o,
               pend_o, irq_o, cnt_o);
      checks++;
      if (exp_o !== 4'b1000 || pend_o !== 4'b1000 || irq_o !== 1'b1) begin
         errors++;
         $display("FAIL ack_vs_set: exp=%b pend=%b irq=%b, required 1000 1000 1",
                  exp_o, pend_o, irq_o);
      end
      pend_ack = 4'b1000;
      @(negedge clk);
      pend_ack = 4'b0000;
      checks++;
      if (ch_pending !== 4'b0 || sched_irq !== 1'b0) begin
         errors++;
         $display("FAIL ack_clear: pend=%b irq=%b, required 0000 0", ch_pending, sched_irq);
      end
      write_ch(4'd3, 16'd0, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [NUM_CH-1:0] want;
      write_ch(4'd0, 16'd2, 1'b1);
      write_ch(4'd2, 16'd1, 1'b1);
      run_tick(1'b0, 4'd0, '0, 1'b0, '0, c_cs, c_wn, c_addr, c_data, exp_mid, exp_o, pend_o,
               irq_o, cnt_o);
      checks++;
      if (exp_o !== 4'b0100) begin
         errors++;
         $display("FAIL pre_collision: exp=%b, required 0100", exp_o);
      end
      // ch 0 count is 1 here; the write lands in the TICK cycle
      run_tick(1'b1, 4'd0, 16'd5, 1'b1, '0, c_cs, c_wn, c_addr, c_data, exp_mid, exp_o, pend_o,
               irq_o, cnt_o);
      checks++;
      if (exp_o !== 4'b0100 || pend_o[0] !== 1'b0) begin
         errors++;
         $display("FAIL wr_collision: exp=%b pend0=%b, required 0100 0", exp_o, pend_o[0]);
      end
      for (int t = 1; t <= 5; t++) begin
         run_tick(1'b0, 4'd0, '0, 1'b0, '0, c_cs, c_wn, c_addr, c_data, exp_mid, exp_o, pend_o,
                  irq_o, cnt_o);
         want = (t == 5) ? 4'b0101 : 4'b0100;
         checks++;
         if (exp_o !== want) begin
            errors++;
            $display("FAIL reload_p5 t=%0d: exp=%b, required %b", t, exp_o, want);
         end
      end
   endtask

   task automatic test_reset_mid();
      tmr_irq = 1'b1;
      @(negedge clk);
      checks++;
      if (tmr_chipselect !== 1'b1 || tmr_address !== 3'd0) begin
         errors++;
         $display("FAIL mid_in_clear: cs=%b addr=%0d, required 1 0", tmr_chipselect, tmr_address);
      end
      reset_n = 1'b0;
      tmr_irq = 1'b0;
      @(negedge clk);
      checks++;
      if (tmr_chipselect !== 1'b0 || tmr_write_n !== 1'b1 || ch_pending !== 4'b0 ||
          tick_count !== 32'd0 || init_done !== 1'b0 || sched_irq !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: cs=%b wn=%b pend=%b cnt=%0d init=%b irq=%b, required 0 1 0000 0 0 0",
                  tmr_chipselect, tmr_write_n, ch_pending, tick_count, init_done, sched_irq);
      end
      reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if (tmr_chipselect !== 1'b1 || tmr_write_n !== 1'b0 || tmr_address !== 3'd1 ||
          tmr_writedata !== 16'h0001) begin
         errors++;
         $display("FAIL reinit_write: cs=%b wn=%b addr=%0d data=%h, required 1 0 1 0001",
                  tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
      end
      @(negedge clk);
      run_tick(1'b0, 4'd0, '0, 1'b0, '0, c_cs, c_wn, c_addr, c_data, exp_mid, exp_o, pend_o,
               irq_o, cnt_o);
      checks++;
      if (exp_o !== 4'b0 || cnt_o !== 32'd1 || init_done !== 1'b1) begin
         errors++;
         $display("FAIL config_lost: exp=%b cnt=%0d init=%b, required 0000 1 1",
                  exp_o, cnt_o, init_done);
      end
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_disabled();
      test_ack();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1);
   end

endmodule
